// File: rtl/uart_pkg.sv
// Shared UART definitions: character width, receive-entry payload and default FIFO depth.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 9;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Receive idle timeout: counts idle cycles while the FIFO holds data and raises a sticky flag.
module uart_rx_timeout
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        empty_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] timeout_i,
  output logic        timeout_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear_i || push_i || pop_i || empty_i) begin
      cnt_d = '0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'(1);
    end
    if (timeout_i != '0 && cnt_d >= timeout_i) begin
      flag_d = 1'b1;
    end
    // Pop or flush acknowledges the timeout; a push alone only restarts the count.
    if (clear_i || pop_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO (first-word-fall-through) with level, overflow and watermark interrupt.
// Define UART_RX_FIFO_TIMEOUT_EN to add the idle-timeout ports and interrupt source.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_W-1:0]        rx_data_i,
  input  logic                     rx_rdy_i,
  input  logic                     rx_err_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_err_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     clear_i,
  input  logic [$clog2(DEPTH):0]   watermark_i,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  input  logic [15:0]              timeout_i,
  output logic                     timeout_o,
`endif
  output logic                     irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic          rdy_q, rdy_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic          empty_q, empty_d, full_q, full_d, overflow_q, overflow_d;
  logic          rdy_rise, push_ok, pop_ok, timeout_irq;
  rx_entry_t     mem_q [DEPTH];
  rx_entry_t     head;

  // Next-state: one push per ready rising edge; a pop frees room for a push into a full FIFO.
  always_comb begin
    rdy_d      = rx_rdy_i;
    rdy_rise   = rx_rdy_i & ~rdy_q;
    pop_ok     = rd_en_i & ~empty_q;
    push_ok    = rdy_rise & (~full_q | pop_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (rdy_rise & full_q & ~pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // rdy_q resets high so a ready level already present at reset release is not a push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{err: rx_err_i, data: UART_DATA_W'(rx_data_i)};
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  uart_rx_timeout u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .empty_i   (empty_q),
    .push_i    (push_ok),
    .pop_i     (pop_ok),
    .timeout_i (timeout_i),
    .timeout_o (timeout_o)
  );
  assign timeout_irq = timeout_o;
`else
  assign timeout_irq = 1'b0;
`endif

  always_comb begin
    head      = mem_q[rd_ptr_q[AW-1:0]];
    rd_data_o = DATA_W'(head.data);
    rd_err_o  = head.err;
    irq_o     = overflow_q | ((watermark_i != '0) && (level_q >= watermark_i)) | timeout_irq;
  end

  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default depth 16, 9-bit characters).
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [8:0] rx_data_i;
  logic       rx_rdy_i, rx_err_i, rd_en_i, clear_i;
  logic [8:0] rd_data_o;
  logic       rd_err_o, empty_o, full_o, overflow_o, irq_o;
  logic [4:0] level_o, watermark_i;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] timeout_i;
  logic        timeout_o;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_fifo dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_data_i   (rx_data_i),
    .rx_rdy_i    (rx_rdy_i),
    .rx_err_i    (rx_err_i),
    .rd_en_i     (rd_en_i),
    .rd_data_o   (rd_data_o),
    .rd_err_o    (rd_err_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .clear_i     (clear_i),
    .watermark_i (watermark_i),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeout_i   (timeout_i),
    .timeout_o   (timeout_o),
`endif
    .irq_o       (irq_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One ready pulse (rise then fall); entry is visible on return.
  task automatic push(input logic [8:0] d, input logic e);
    rx_data_i = d;
    rx_err_i  = e;
    rx_rdy_i  = 1'b1;
    step();
    rx_rdy_i  = 1'b0;
    step();
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] exp);
    chk(tag, 32'(rd_data_o), 32'(exp));
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; rx_data_i = '0; rx_rdy_i = 1'b1; rx_err_i = 1'b0;
    rd_en_i = 1'b0; clear_i = 1'b0; watermark_i = '0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_i = 16'd0;
`endif
    #23 rst_ni = 1'b1;
    step();
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    step(); step();
    chk("rdy_high_at_reset_no_push", 32'(level_o), 32'd0);
    rx_rdy_i = 1'b0;
    step();

    // Long ready pulse yields exactly one entry.
    rx_data_i = 9'h0A5;
    rx_rdy_i  = 1'b1;
    step();
    chk("long_pulse_level", 32'(level_o), 32'd1);
    chk("long_pulse_data", 32'(rd_data_o), 32'h0A5);
    chk("long_pulse_empty", 32'(empty_o), 32'd0);
    for (int i = 0; i < 49; i++) step();
    chk("long_pulse_still_one", 32'(level_o), 32'd1);
    rx_rdy_i = 1'b0;
    step();
    pop_chk("pop_0a5", 9'h0A5);
    chk("after_pop_empty", 32'(empty_o), 32'd1);

    // Fill, then overflow with 0x1FF.
    for (int i = 0; i < 16; i++) push(9'(i), 1'b0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_level", 32'(level_o), 32'd16);
    chk("fill_no_ovf", 32'(overflow_o), 32'd0);
    push(9'h1FF, 1'b0);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_irq", 32'(irq_o), 32'd1);
    chk("ovf_level", 32'(level_o), 32'd16);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain_%0d", i), 9'(i));
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clear_ovf", 32'(overflow_o), 32'd0);
    chk("clear_irq", 32'(irq_o), 32'd0);

    // Full FIFO: push with simultaneous pop.
    for (int i = 0; i < 16; i++) push(9'(i), 1'b0);
    rx_data_i = 9'h155; rx_rdy_i = 1'b1; rd_en_i = 1'b1;
    step();
    rx_rdy_i = 1'b0; rd_en_i = 1'b0;
    chk("pp_full_level", 32'(level_o), 32'd16);
    chk("pp_full_ovf", 32'(overflow_o), 32'd0);
    chk("pp_full_full", 32'(full_o), 32'd1);
    step();
    for (int i = 1; i < 16; i++) pop_chk($sformatf("pp_drain_%0d", i), 9'(i));
    pop_chk("pp_last_155", 9'h155);
    chk("pp_empty", 32'(empty_o), 32'd1);

    // Watermark interrupt.
    watermark_i = 5'd4;
    for (int i = 0; i < 3; i++) push(9'h010 + 9'(i), 1'b0);
    chk("wm_3_irq", 32'(irq_o), 32'd0);
    push(9'h013, 1'b0);
    chk("wm_4_irq", 32'(irq_o), 32'd1);
    pop_chk("wm_pop", 9'h010);
    chk("wm_pop_irq", 32'(irq_o), 32'd0);
    rx_data_i = 9'h077; rx_rdy_i = 1'b1; clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_push_level", 32'(level_o), 32'd0);
    chk("clr_push_empty", 32'(empty_o), 32'd1);
    step();
    rx_rdy_i = 1'b0;
    chk("clr_push_no_late", 32'(level_o), 32'd0);
    watermark_i = '0;
    step();

    // Parity-error flag and pop on empty.
    push(9'h033, 1'b1);
    chk("err_flag", 32'(rd_err_o), 32'd1);
    chk("err_data", 32'(rd_data_o), 32'h033);
    pop_chk("err_pop", 9'h033);
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    chk("empty_pop_level", 32'(level_o), 32'd0);
    chk("empty_pop_empty", 32'(empty_o), 32'd1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    timeout_i = 16'd100;
    push(9'h044, 1'b0);
    for (int i = 0; i < 98; i++) step();
    chk("to_before", 32'(timeout_o), 32'd0);
    step();
    chk("to_hit", 32'(timeout_o), 32'd1);
    chk("to_irq", 32'(irq_o), 32'd1);
    pop_chk("to_pop", 9'h044);
    chk("to_cleared", 32'(timeout_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
